// File: rtl/cache_pkg.sv
// Shared types for the posted-write buffer between the core and cache_controller.
// Used by cache_wbuf (forwarding option: CACHE_WBUF_FWD_EN).
package cache_pkg;
  localparam int CACHE_ADDR_W = 21;
  localparam int CACHE_DATA_W = 32;

  typedef logic [CACHE_ADDR_W-1:0] addr_t;
  typedef logic [CACHE_DATA_W-1:0] data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wbuf_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT
  } wbuf_state_e;
endpackage

// File: rtl/cache_wbuf_fifo.sv
// Write-buffer storage: circular FIFO with wrap-bit pointers and a youngest-match
// address lookup (enabled by LOOKUP_EN, which the top sets from CACHE_WBUF_FWD_EN).
module wbuf_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit LOOKUP_EN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  wbuf_entry_t push_entry,
  input  logic        pop,
  output wbuf_entry_t head,
  output logic        full,
  output logic        empty,
  input  addr_t       lk_addr,
  output logic        lk_hit,
  output data_t       lk_data
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wr_ptr, rd_ptr, count;
  logic [IDX_W-1:0] idx;
  wbuf_entry_t      mem [DEPTH];

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[IDX_W-1:0]] <= push_entry;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr[IDX_W-1:0] + IDX_W'(i);
      if (LOOKUP_EN && (i < int'(count)) && (mem[idx].addr == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = mem[idx].data;
      end
    end
  end
endmodule

// File: rtl/cache_wbuf.sv
// Posted-write buffer: acks core stores at once, drains them in order, and
// serialises reads behind them. Define CACHE_WBUF_FWD_EN to forward reads from buffered writes.
//   state    | meaning
//   IDLE     | nothing outstanding downstream
//   WR_ISSUE | presenting FIFO head as a downstream write
//   WR_WAIT  | waiting for the write response
//   RD_ISSUE | presenting the held read address downstream
//   RD_WAIT  | waiting for read data to return to the core
module cache_wbuf
  import cache_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] up_req_addr,
  input  logic [DATA_W-1:0] up_req_data,
  input  logic              up_req_wr,
  input  logic              up_req_valid,
  output logic              up_req_ready,
  output logic [DATA_W-1:0] up_rsp_data,
  output logic              up_rsp_valid,
  output logic [ADDR_W-1:0] dn_req_addr,
  output logic [DATA_W-1:0] dn_req_data,
  output logic              dn_req_wr,
  output logic              dn_req_valid,
  input  logic              dn_req_ready,
  input  logic [DATA_W-1:0] dn_rsp_data,
  input  logic              dn_rsp_valid
);
`ifdef CACHE_WBUF_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  wbuf_state_e       state, state_nxt;
  logic              rd_pending;
  logic [ADDR_W-1:0] rd_addr;
  wbuf_entry_t       push_entry, head;
  logic              full, empty, lk_hit;
  data_t             lk_data;
  logic              wr_accept, rd_accept, fwd_hit, rd_miss, rd_done, pop;

  assign up_req_ready = !reset && !rd_pending && (up_req_wr ? !full : 1'b1);
  assign wr_accept    = up_req_valid && up_req_ready && up_req_wr;
  assign rd_accept    = up_req_valid && up_req_ready && !up_req_wr;
  assign fwd_hit      = rd_accept && lk_hit;
  assign rd_miss      = rd_accept && !lk_hit;
  assign rd_done      = (state == RD_WAIT) && dn_rsp_valid;
  assign pop          = (state == WR_ISSUE) && dn_req_ready;
  assign push_entry   = '{addr: up_req_addr, data: up_req_data};

  wbuf_fifo #(.DEPTH(DEPTH), .LOOKUP_EN(FWD_EN)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (wr_accept),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .lk_addr    (up_req_addr),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_pending   <= 1'b0;
      rd_addr      <= '0;
      up_rsp_valid <= 1'b0;
      up_rsp_data  <= '0;
    end else begin
      state        <= state_nxt;
      up_rsp_valid <= wr_accept || fwd_hit || rd_done;
      up_rsp_data  <= fwd_hit ? lk_data : (rd_done ? dn_rsp_data : '0);
      if (rd_miss) begin
        rd_pending <= 1'b1;
        rd_addr    <= up_req_addr;
      end else if (rd_done) begin
        rd_pending <= 1'b0;
      end
    end
  end

  // A read accepted this cycle goes straight to RD_ISSUE when no writes are buffered.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!empty)                      state_nxt = WR_ISSUE;
        else if (rd_pending || rd_miss)  state_nxt = RD_ISSUE;
      end
      WR_ISSUE: if (dn_req_ready) state_nxt = WR_WAIT;
      WR_WAIT:  if (dn_rsp_valid) state_nxt = IDLE;
      RD_ISSUE: if (dn_req_ready) state_nxt = RD_WAIT;
      RD_WAIT:  if (dn_rsp_valid) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dn_req_valid = 1'b0;
    dn_req_wr    = 1'b0;
    dn_req_addr  = '0;
    dn_req_data  = '0;
    if (state == WR_ISSUE) begin
      dn_req_valid = 1'b1;
      dn_req_wr    = 1'b1;
      dn_req_addr  = head.addr;
      dn_req_data  = head.data;
    end else if (state == RD_ISSUE) begin
      dn_req_valid = 1'b1;
      dn_req_addr  = rd_addr;
    end
  end
endmodule

// File: tb/tb_cache_wbuf.sv
// Scoreboard bench for cache_wbuf: program-order reference memory, buffered-write
// queue and a downstream responder model. Honours CACHE_WBUF_FWD_EN.
module tb_cache_wbuf;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
`ifdef CACHE_WBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] up_req_addr;
  logic [DATA_W-1:0] up_req_data;
  logic              up_req_wr, up_req_valid, up_req_ready;
  logic [DATA_W-1:0] up_rsp_data;
  logic              up_rsp_valid;
  logic [ADDR_W-1:0] dn_req_addr;
  logic [DATA_W-1:0] dn_req_data;
  logic              dn_req_wr, dn_req_valid, dn_req_ready;
  logic [DATA_W-1:0] dn_rsp_data;
  logic              dn_rsp_valid;

  always #5 clk = ~clk;

  cache_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .up_req_addr(up_req_addr), .up_req_data(up_req_data), .up_req_wr(up_req_wr),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
    .up_rsp_data(up_rsp_data), .up_rsp_valid(up_rsp_valid),
    .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data), .dn_req_wr(dn_req_wr),
    .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
    .dn_rsp_data(dn_rsp_data), .dn_rsp_valid(dn_rsp_valid)
  );

  typedef struct { logic [DATA_W-1:0] data; bit miss; int due; } up_exp_t;
  typedef struct { bit wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } dn_exp_t;

  int checks = 0, errors = 0, cyc = 0;
  up_exp_t up_q[$];
  dn_exp_t dn_q[$];
  logic [ADDR_W-1:0] buf_q[$];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] dmem    [logic [ADDR_W-1:0]];
  bit rd_pend_m = 0, dn_busy = 0, dn_rd = 0, inj_rsp = 0, stall_prev = 0, hit;
  logic [ADDR_W-1:0] dn_rd_addr;
  logic [54:0] pay_prev;
  int rsp_due = 0, last_rsp_cyc = 0, last_acc_cyc = 0, last_hs_cyc = 0, n_hs = 0;
  int ready_mode = 1, rsp_dly_min = 1, rsp_dly_max = 3;
  up_exp_t ue;
  dn_exp_t de;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [DATA_W-1:0] mem_default(logic [ADDR_W-1:0] a);
    return {11'h5A5, a};
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  // Reference model and monitors; all values sampled just before the edge.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      up_q.delete(); dn_q.delete(); buf_q.delete();
      rd_pend_m = 0; dn_busy = 0; stall_prev = 0;
      ref_mem = dmem;  // buffered writes are lost; memory holds only what drained
    end else begin
      if (dn_rsp_valid && dn_busy) begin
        dn_busy = 0;
        last_rsp_cyc = cyc;
      end
      if (up_rsp_valid) begin
        if (up_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_up_rsp: got data %0h expected no response (cycle %0d)", up_rsp_data, cyc);
        end else begin
          ue = up_q.pop_front();
          chk("up_rsp_data", up_rsp_data, ue.data);
          chk("up_rsp_cycle", cyc, ue.miss ? last_rsp_cyc + 1 : ue.due);
          if (ue.miss) rd_pend_m = 0;
        end
      end
      if (up_req_valid)
        chk("up_req_ready", up_req_ready, !rd_pend_m && (up_req_wr ? (buf_q.size() < DEPTH) : 1'b1));
      if (stall_prev)
        chk("dn_hold", {dn_req_valid, dn_req_wr, dn_req_addr, dn_req_data}, pay_prev);
      if (up_req_valid && up_req_ready) begin
        last_acc_cyc = cyc;
        if (up_req_wr) begin
          ref_mem[up_req_addr] = up_req_data;
          buf_q.push_back(up_req_addr);
          ue.data = '0; ue.miss = 0; ue.due = cyc + 1;
          up_q.push_back(ue);
          de.wr = 1; de.addr = up_req_addr; de.data = up_req_data;
          dn_q.push_back(de);
        end else begin
          hit = 0;
          if (FWD) foreach (buf_q[i]) if (buf_q[i] == up_req_addr) hit = 1;
          ue.data = ref_rd(up_req_addr); ue.miss = !hit; ue.due = cyc + 1;
          up_q.push_back(ue);
          if (!hit) begin
            rd_pend_m = 1;
            de.wr = 0; de.addr = up_req_addr; de.data = '0;
            dn_q.push_back(de);
          end
        end
      end
      if (dn_req_valid && dn_req_ready) begin
        n_hs++;
        last_hs_cyc = cyc;
        if (dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dn_req: got addr %0h wr %0b expected none (cycle %0d)", dn_req_addr, dn_req_wr, cyc);
        end else begin
          de = dn_q.pop_front();
          chk("dn_req_wr", dn_req_wr, de.wr);
          chk("dn_req_addr", dn_req_addr, de.addr);
          if (de.wr) chk("dn_req_data", dn_req_data, de.data);
        end
        if (dn_req_wr) begin
          dmem[dn_req_addr] = dn_req_data;
          if (buf_q.size() > 0) void'(buf_q.pop_front());
        end
        dn_busy = 1;
        dn_rd = !dn_req_wr;
        dn_rd_addr = dn_req_addr;
        rsp_due = cyc + $urandom_range(rsp_dly_min, rsp_dly_max) - 1;
      end
      stall_prev = dn_req_valid && !dn_req_ready;
      pay_prev = {dn_req_valid, dn_req_wr, dn_req_addr, dn_req_data};
    end
  end

  // Downstream cache_controller model.
  always @(negedge clk) begin
    dn_req_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    dn_rsp_valid = inj_rsp || (dn_busy && cyc == rsp_due);
    if (dn_busy && dn_rd)
      dn_rsp_data = dmem.exists(dn_rd_addr) ? dmem[dn_rd_addr] : mem_default(dn_rd_addr);
    else
      dn_rsp_data = $urandom;
  end

  task automatic send(bit wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    int n = 0;
    @(negedge clk);
    up_req_valid = 1; up_req_wr = wr; up_req_addr = a; up_req_data = d;
    #4;
    while (!up_req_ready) begin
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL send_timeout: got ready 0 for %0d cycles expected accept (addr %0h)", n, a);
        up_req_valid = 0;
        return;
      end
      @(negedge clk);
      #4;
    end
    @(posedge clk);
    #1 up_req_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (up_q.size() != 0 || dn_q.size() != 0 || dn_busy || dn_req_valid) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d up / %0d dn pending expected 0", up_q.size(), dn_q.size());
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_up_req_ready"}, up_req_ready, 0);
    chk({tag, "_up_rsp_valid"}, up_rsp_valid, 0);
    chk({tag, "_up_rsp_data"}, up_rsp_data, 0);
    chk({tag, "_dn_req_valid"}, dn_req_valid, 0);
    chk({tag, "_dn_req_addr"}, dn_req_addr, 0);
    chk({tag, "_dn_req_data"}, dn_req_data, 0);
    chk({tag, "_dn_req_wr"}, dn_req_wr, 0);
  endtask

  initial begin
    int hs0, n;
    up_req_valid = 0; up_req_wr = 0; up_req_addr = '0; up_req_data = '0;
    reset = 1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 0;

    // Single write on empty buffer: ack at +1, downstream issue at +2.
    ready_mode = 1;
    send(1, 21'h10, 32'hA5A5A5A5);
    wait_idle();
    chk("wr_issue_latency", last_hs_cyc, last_acc_cyc + 2);

    // Five writes against a stalled downstream; fifth must wait for a pop.
    ready_mode = 0;
    fork
      for (int i = 0; i < 5; i++) send(1, 21'h100 + 21'(i), $urandom);
      begin repeat (30) @(negedge clk); ready_mode = 1; end
    join
    wait_idle();

    // Reads ordered behind buffered writes.
    ready_mode = 2;
    send(1, 21'h20, $urandom);
    send(1, 21'h21, $urandom);
    send(0, 21'h30, '0);
    wait_idle();

    // Read on idle, empty buffer issues downstream the next cycle.
    ready_mode = 1;
    send(0, 21'h50, '0);
    wait_idle();
    chk("rd_issue_latency", last_hs_cyc, last_acc_cyc + 1);

    // Same-address writes then read while downstream stalls.
    ready_mode = 0;
    fork
      begin send(1, 21'h40, 32'd1); send(1, 21'h40, 32'd2); send(0, 21'h40, '0); end
      begin repeat (20) @(negedge clk); ready_mode = 1; end
    join
    wait_idle();

    // Reset in WR_WAIT with three entries buffered.
    ready_mode = 0; rsp_dly_min = 30; rsp_dly_max = 30;
    for (int i = 0; i < 4; i++) send(1, 21'h60 + 21'(i), $urandom);
    hs0 = n_hs; n = 0;
    ready_mode = 1;
    while (n_hs == hs0 && n < 50) begin @(posedge clk); #1 n++; end
    ready_mode = 0;
    chk("wr_wait_handshake", n_hs, hs0 + 1);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    reset = 0;
    @(posedge clk); #1 inj_rsp = 1;
    @(posedge clk); #1 inj_rsp = 0;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_dn_idle", dn_req_valid, 0);
    end
    rsp_dly_min = 1; rsp_dly_max = 3;

    // Pointer wrap: write/drain repeatedly.
    ready_mode = 1;
    for (int i = 0; i < 10; i++) begin
      send(1, 21'h200 + 21'(i * 3), $urandom);
      wait_idle();
    end

    // Random mix over a small address window to exercise forwarding and full.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 2) != 0, 21'h40 + 21'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    ready_mode = 1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
